// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM encoding, frame width and timing helpers.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  // Sample index closest to the bit centre when counting from the start edge.
  function automatic int mid_sample(input int oversample);
    return oversample / 2 - 1;
  endfunction

  function automatic int baud_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock pulse every DIV enabled clocks, restartable by clear.
// Tick is combinational from the counter; clear takes priority so ticks realign to a start edge.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && !clear && (cnt == LAST);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchronized, oversampled line decoded into bytes with frame/parity/overrun flags.
// Byte valid ~9.5 bit times after the start edge; an unacknowledged byte is overwritten and flags Overrun.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Rx,
  input  logic       RxAck,
  output logic [7:0] RxData,
  output logic       RxValid,
  output logic       FrameErr,
  output logic       ParityErr,
  output logic       Overrun,
  output logic       Busy
);

  localparam int              DIV      = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int              SW       = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int              BW       = $clog2(DATA_BITS);
  localparam logic [SW-1:0]   MID_IDX  = SW'(mid_sample(OVERSAMPLE));
  localparam logic [SW-1:0]   LAST_IDX = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic            ODD      = (PARITY_ODD != 0);

  logic [1:0]           rx_sync;
  logic                 rx_hist;
  logic                 rx_s;
  logic [2:0]           line_seen;
  uart_state_t          state_q, state_d;
  logic [SW-1:0]        samp_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err_q;
  logic                 tick;
  logic                 mid;
  logic                 start_det;
  logic                 complete;

  assign rx_s = rx_sync[1];
  assign mid  = tick && (samp_cnt == MID_IDX);
  assign Busy = (state_q != IDLE);

  // line_seen marks when rx_hist holds a real line sample, so a line low out of reset is no edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_sync   <= 2'b11;
      rx_hist   <= 1'b1;
      line_seen <= '0;
    end else begin
      rx_sync   <= {rx_sync[0], Rx};
      rx_hist   <= rx_s;
      line_seen <= {line_seen[1:0], 1'b1};
    end
  end

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .clear  (start_det),
    .enable (Busy),
    .tick   (tick)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_det = 1'b0;
    complete  = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_seen[2] && rx_hist && !rx_s) begin
          start_det = 1'b1;
          state_d   = START;
        end
      end
      START:  if (mid) state_d = rx_s ? IDLE : DATA;
      DATA:   if (mid && bit_cnt == LAST_BIT) state_d = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (mid) state_d = STOP;
      // Leave at the stop-bit centre so a back-to-back start edge is not missed.
      STOP: begin
        if (mid) begin
          state_d  = IDLE;
          complete = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      samp_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_err_q <= 1'b0;
    end else if (start_det) begin
      samp_cnt  <= '0;
      bit_cnt   <= '0;
      par_err_q <= 1'b0;
    end else begin
      if (tick) begin
        samp_cnt <= (samp_cnt == LAST_IDX) ? '0 : samp_cnt + 1'b1;
      end
      if (state_q == DATA && mid) begin
        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state_q == PARITY && mid) begin
        par_err_q <= rx_s ^ (^shreg) ^ ODD;
      end
    end
  end

  // A completion wins over an ack in the same cycle; the ack only suppresses Overrun.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      RxData    <= '0;
      RxValid   <= 1'b0;
      FrameErr  <= 1'b0;
      ParityErr <= 1'b0;
      Overrun   <= 1'b0;
    end else if (complete) begin
      RxData    <= shreg;
      RxValid   <= 1'b1;
      FrameErr  <= !rx_s;
      ParityErr <= par_err_q;
      if (RxValid && !RxAck) begin
        Overrun <= 1'b1;
      end
    end else if (RxAck && RxValid) begin
      RxValid <= 1'b0;
      Overrun <= 1'b0;
    end
  end

endmodule
